// File: rtl/axis_sink_check_if.sv
// AXI-Stream channel bundle between a stream source and the sink checker.
interface axis_sink_check_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;
    logic                    tvalid;
    logic                    tready;

    modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_sink_check.sv
// AXI-Stream sink: applies a tready backpressure pattern, checks beats against the
// {FIXED_DATA, beat index} source pattern plus tkeep/tlast, and counts frames and errors.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | after reset; tready low, waiting for start
//   ST_RECV | receiving and checking beats; tready follows READY_PATTERN
//   ST_DONE | NUM_FRAMES frames seen; tready low, results held until start
module axis_sink_check #(
    parameter int                             DATA_WIDTH    = 32,
    parameter int                             FRAME_LENGTH  = 16,
    parameter int                             NUM_FRAMES    = 1,
    parameter int                             CNTR_WIDTH    = 4,
    parameter logic [DATA_WIDTH-CNTR_WIDTH-1:0] FIXED_DATA  = 28'h666A500,
    parameter logic [15:0]                    READY_PATTERN = 16'hFFFF
) (
    input  logic                aclk,
    input  logic                arstn,
    input  logic                start,
    axis_sink_check_if.slave    s_axis,
    output logic                busy,
    output logic                done,
    output logic [15:0]         frame_cnt,
    output logic [15:0]         err_cnt,
    output logic [2:0]          err_flags
);

    localparam int                      BEAT_W     = (FRAME_LENGTH > 1) ? $clog2(FRAME_LENGTH) : 1;
    localparam logic [BEAT_W-1:0]       LAST_BEAT  = BEAT_W'(FRAME_LENGTH - 1);
    localparam logic [BEAT_W-1:0]       BEAT_ONE   = BEAT_W'(1);
    localparam logic [DATA_WIDTH/8-1:0] KEEP_ALL   = '1;
    localparam logic [15:0]             NUM_FRM_16 = 16'(NUM_FRAMES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            pat_idx_q, pat_idx_d;
    logic [BEAT_W-1:0]     beat_idx_q, beat_idx_d;
    logic                  tready_q, tready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic [15:0]           err_cnt_q, err_cnt_d;
    logic [2:0]            err_flags_q, err_flags_d;

    logic                  beat;
    logic                  is_last_idx;
    logic                  data_err;
    logic                  keep_err;
    logic                  len_err;
    logic                  eof;
    logic [15:0]           frame_cnt_inc;
    logic [DATA_WIDTH-1:0] exp_data;

    always_comb begin
        state_d       = state_q;
        pat_idx_d     = pat_idx_q;
        beat_idx_d    = beat_idx_q;
        tready_d      = tready_q;
        busy_d        = busy_q;
        done_d        = done_q;
        frame_cnt_d   = frame_cnt_q;
        err_cnt_d     = err_cnt_q;
        err_flags_d   = err_flags_q;

        beat          = (state_q == ST_RECV) && s_axis.tvalid && tready_q;
        exp_data      = {FIXED_DATA, CNTR_WIDTH'(beat_idx_q)};
        is_last_idx   = (beat_idx_q == LAST_BEAT);
        data_err      = (s_axis.tdata != exp_data);
        keep_err      = (s_axis.tkeep != KEEP_ALL);
        // tlast must coincide exactly with the last index: covers early and missing tlast
        len_err       = (s_axis.tlast != is_last_idx);
        eof           = s_axis.tlast || is_last_idx;
        frame_cnt_inc = frame_cnt_q + 16'd1;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_RECV;
                    pat_idx_d   = 4'd0;
                    beat_idx_d  = '0;
                    tready_d    = READY_PATTERN[0];
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    frame_cnt_d = '0;
                    err_cnt_d   = '0;
                    err_flags_d = '0;
                end
            end
            ST_RECV: begin
                // pat_idx_q is the index of the current cycle; tready is registered one ahead
                pat_idx_d = pat_idx_q + 4'd1;
                tready_d  = READY_PATTERN[pat_idx_d];
                if (beat) begin
                    err_flags_d = err_flags_q | {len_err, keep_err, data_err};
                    if ((data_err || keep_err || len_err) && (err_cnt_q != 16'hFFFF)) begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
                    if (eof) begin
                        beat_idx_d  = '0;
                        frame_cnt_d = frame_cnt_inc;
                        if (frame_cnt_inc == NUM_FRM_16) begin
                            state_d  = ST_DONE;
                            tready_d = 1'b0;
                            busy_d   = 1'b0;
                            done_d   = 1'b1;
                        end
                    end else begin
                        beat_idx_d = beat_idx_q + BEAT_ONE;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                tready_d = 1'b0;
                busy_d   = 1'b0;
                done_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state_q     <= ST_IDLE;
            pat_idx_q   <= '0;
            beat_idx_q  <= '0;
            tready_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            err_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            pat_idx_q   <= pat_idx_d;
            beat_idx_q  <= beat_idx_d;
            tready_q    <= tready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_flags_q <= err_flags_d;
        end
    end

    assign s_axis.tready = tready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign frame_cnt     = frame_cnt_q;
    assign err_cnt       = err_cnt_q;
    assign err_flags     = err_flags_q;

endmodule

// File: tb/tb_axis_sink_check.sv
// Bench for axis_sink_check: table of frame scenarios, hand-written reset/restart
// sequences and randomized streams checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_axis_sink_check;
    localparam int          DW    = 32;
    localparam int          ND    = 4;
    localparam logic [27:0] FIXED = 28'h666A500;
    localparam logic [15:0] PAT  [ND] = '{16'hFFFF, 16'hAAAA, 16'hFFFF, 16'hB6D9};
    localparam int          FLEN [ND] = '{16, 16, 16, 20};
    localparam int          NFR  [ND] = '{1, 1, 2, 3};

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    typedef struct {
        int          dut;
        int          bad_data;
        int          bad_keep;
        int          early_last;
        bit          miss_last;
        int          valid_pct;
        logic [2:0]  exp_flags;
        int          exp_ec;
        int          exp_fc;
    } vec_t;

    logic          clk = 1'b0;
    logic          arstn = 1'b0;
    logic [ND-1:0] start_v = '0;
    logic [31:0]   src_tdata = '0;
    logic [3:0]    src_tkeep = '0;
    logic          src_tlast = 1'b0;
    logic          src_tvalid = 1'b0;

    logic          tready_w [ND];
    logic          busy_w   [ND];
    logic          done_w   [ND];
    logic [15:0]   fc_w     [ND];
    logic [15:0]   ec_w     [ND];
    logic [2:0]    fl_w     [ND];

    int            sel = 0;
    logic          tready_sel, busy_sel, done_sel;
    logic [15:0]   fc_sel, ec_sel;
    logic [2:0]    fl_sel;

    int            n_checks = 0;
    int            n_fail = 0;

    int            m_idx, m_fc, m_ec;
    logic [2:0]    m_fl;
    bit            m_done;
    int            rc;
    bit            last_pre_done;
    beat_t         src_q [$];
    vec_t          vecs [10];

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < ND; g++) begin : g_dut
            axis_sink_check_if #(.DATA_WIDTH(DW)) s_if ();
            assign s_if.tdata  = src_tdata;
            assign s_if.tkeep  = src_tkeep;
            assign s_if.tlast  = src_tlast;
            assign s_if.tvalid = src_tvalid;
            assign tready_w[g] = s_if.tready;

            axis_sink_check #(
                .DATA_WIDTH(DW), .FRAME_LENGTH(FLEN[g]), .NUM_FRAMES(NFR[g]),
                .CNTR_WIDTH(4), .FIXED_DATA(FIXED), .READY_PATTERN(PAT[g])
            ) dut (
                .aclk(clk), .arstn(arstn), .start(start_v[g]), .s_axis(s_if.slave),
                .busy(busy_w[g]), .done(done_w[g]), .frame_cnt(fc_w[g]),
                .err_cnt(ec_w[g]), .err_flags(fl_w[g])
            );
        end
    endgenerate

    assign tready_sel = tready_w[sel];
    assign busy_sel   = busy_w[sel];
    assign done_sel   = done_w[sel];
    assign fc_sel     = fc_w[sel];
    assign ec_sel     = ec_w[sel];
    assign fl_sel     = fl_w[sel];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (dut %0d, t=%0t): got %0h expected %0h", name, sel, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rc++;
    endtask

    task automatic model_start();
        m_idx = 0; m_fc = 0; m_ec = 0; m_fl = 3'b000; m_done = 1'b0;
    endtask

    // Frame-level reference: expected data is FIXED followed by the beat number mod 16
    task automatic model_beat(input beat_t b);
        int          fl;
        logic [2:0]  e;
        logic [31:0] exp_data;
        fl = FLEN[sel];
        e  = 3'b000;
        if (m_done) return;
        exp_data = (32'(FIXED) << 4) | 32'(m_idx % 16);
        if (b.data != exp_data) e[0] = 1'b1;
        if (b.keep != 4'hF) e[1] = 1'b1;
        if (b.last && (m_idx < fl - 1)) e[2] = 1'b1;
        if (!b.last && (m_idx == fl - 1)) e[2] = 1'b1;
        m_fl = m_fl | e;
        if ((e != 3'b000) && (m_ec < 65535)) m_ec++;
        if (b.last || (m_idx == fl - 1)) begin
            m_idx = 0;
            m_fc++;
            if (m_fc == NFR[sel]) m_done = 1'b1;
        end else begin
            m_idx++;
        end
    endtask

    task automatic do_start();
        start_v[sel] = 1'b1;
        @(posedge clk);
        #1;
        start_v = '0;
        rc = 0;
        model_start();
    endtask

    task automatic run_stream(input int valid_pct, input int max_cycles);
        beat_t       b;
        bit          acc;
        int          cyc;
        logic [15:0] p;
        cyc = 0;
        p = PAT[sel];
        src_tvalid = 1'b0;
        b = '{data: '0, keep: '0, last: 1'b0};
        while (((src_q.size() > 0) || src_tvalid) && (cyc < max_cycles)) begin
            if (!src_tvalid && (src_q.size() > 0) && ($urandom_range(99) < valid_pct)) begin
                b = src_q.pop_front();
                src_tdata  = b.data;
                src_tkeep  = b.keep;
                src_tlast  = b.last;
                src_tvalid = 1'b1;
            end
            check("tready_pattern", 32'(tready_sel), m_done ? 32'd0 : 32'(p[rc % 16]));
            acc = src_tvalid && tready_sel;
            last_pre_done = done_sel;
            tick();
            cyc++;
            if (acc) begin
                src_tvalid = 1'b0;
                model_beat(b);
                check("beat_frame_cnt", 32'(fc_sel), 32'(m_fc));
                check("beat_err_cnt", 32'(ec_sel), 32'(m_ec));
                check("beat_err_flags", 32'(fl_sel), 32'(m_fl));
                check("beat_done", 32'(done_sel), 32'(m_done));
                check("beat_busy", 32'(busy_sel), 32'(!m_done));
            end
        end
        check("stream_budget", 32'(cyc < max_cycles), 32'd1);
        src_tvalid = 1'b0;
    endtask

    task automatic check_end(input string tag, input int fc, input int ec, input logic [2:0] fl);
        check({tag, "_done_latency"}, 32'(last_pre_done), 32'd0);
        check({tag, "_done"}, 32'(done_sel), 32'd1);
        check({tag, "_busy"}, 32'(busy_sel), 32'd0);
        check({tag, "_tready"}, 32'(tready_sel), 32'd0);
        check({tag, "_frame_cnt"}, 32'(fc_sel), 32'(fc));
        check({tag, "_err_cnt"}, 32'(ec_sel), 32'(ec));
        check({tag, "_err_flags"}, 32'(fl_sel), 32'(fl));
    endtask

    task automatic push_good_frame(input int n);
        beat_t x;
        for (int b = 0; b < n; b++) begin
            x.data = (32'(FIXED) << 4) | 32'(b);
            x.keep = 4'hF;
            x.last = (b == 15);
            src_q.push_back(x);
        end
    endtask

    task automatic apply_vec(input int i);
        vec_t  v;
        beat_t x;
        v = vecs[i];
        sel = v.dut;
        do_start();
        src_q.delete();
        for (int f = 0; f < NFR[v.dut]; f++) begin
            for (int b = 0; b < 16; b++) begin
                x.data = (32'(FIXED) << 4) | 32'(b);
                x.keep = 4'hF;
                x.last = (b == 15);
                if (b == v.bad_data) x.data = 32'h0666A5FF;
                if (b == v.bad_keep) x.keep = 4'h7;
                if (v.miss_last && (b == 15)) x.last = 1'b0;
                if (b == v.early_last) x.last = 1'b1;
                src_q.push_back(x);
                if (b == v.early_last) break;
            end
        end
        run_stream(v.valid_pct, 500);
        check_end($sformatf("vec%0d", i), v.exp_fc, v.exp_ec, v.exp_flags);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t tmp [$];
        beat_t x;
        int    s, n;

        //         dut bad_d bad_k early miss pct  flags   ec fc
        vecs[0] = '{0, -1,   -1,   -1,   0,   100, 3'b000, 0, 1};
        vecs[1] = '{0,  5,   -1,   -1,   0,   100, 3'b001, 1, 1};
        vecs[2] = '{0, -1,   -1,    9,   0,   100, 3'b100, 1, 1};
        vecs[3] = '{0, -1,   -1,   -1,   1,   100, 3'b100, 1, 1};
        vecs[4] = '{0, -1,    3,   -1,   0,   100, 3'b010, 1, 1};
        vecs[5] = '{0,  2,    2,   -1,   0,   100, 3'b011, 1, 1};
        vecs[6] = '{1, -1,   -1,   -1,   0,   100, 3'b000, 0, 1};
        vecs[7] = '{0, -1,   -1,   -1,   0,    40, 3'b000, 0, 1};
        vecs[8] = '{1, 12,   -1,   -1,   0,    60, 3'b001, 1, 1};
        vecs[9] = '{2, -1,   -1,   -1,   0,   100, 3'b000, 0, 2};

        rc = 0;
        model_start();
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < ND; g++) begin
            sel = g;
            #0;
            check("reset_tready", 32'(tready_sel), 32'd0);
            check("reset_busy", 32'(busy_sel), 32'd0);
            check("reset_done", 32'(done_sel), 32'd0);
            check("reset_outputs", {fc_sel, ec_sel[12:0], fl_sel}, 32'd0);
        end
        arstn = 1'b1;
        tick();
        sel = 0;
        #0;
        check("idle_no_start_tready", 32'(tready_sel), 32'd0);

        for (int i = 0; i < 10; i++) apply_vec(i);

        // Reset while beat 7 is on the bus, then a clean frame
        sel = 0;
        do_start();
        src_q.delete();
        push_good_frame(7);
        run_stream(100, 100);
        src_tdata  = (32'(FIXED) << 4) | 32'd7;
        src_tkeep  = 4'hF;
        src_tlast  = 1'b0;
        src_tvalid = 1'b1;
        check("pre_reset_busy", 32'(busy_sel), 32'd1);
        arstn = 1'b0;
        #1;
        check("midreset_tready", 32'(tready_sel), 32'd0);
        check("midreset_busy", 32'(busy_sel), 32'd0);
        check("midreset_done", 32'(done_sel), 32'd0);
        check("midreset_frame_cnt", 32'(fc_sel), 32'd0);
        check("midreset_counts", {ec_sel, 13'd0, fl_sel}, 32'd0);
        src_tvalid = 1'b0;
        #3;
        arstn = 1'b1;
        tick();
        check("post_reset_idle", 32'(busy_sel), 32'd0);
        apply_vec(0);

        // Two frames with a start pulse during reception that must be ignored
        sel = 2;
        do_start();
        src_q.delete();
        push_good_frame(16);
        run_stream(100, 100);
        check("nf2_mid_frame_cnt", 32'(fc_sel), 32'd1);
        check("nf2_mid_done", 32'(done_sel), 32'd0);
        check("nf2_mid_busy", 32'(busy_sel), 32'd1);
        check("nf2_start_tready", 32'(tready_sel), 32'(PAT[2][0]));
        start_v[2] = 1'b1;
        tick();
        start_v = '0;
        check("nf2_start_ignored_fc", 32'(fc_sel), 32'd1);
        check("nf2_start_ignored_busy", 32'(busy_sel), 32'd1);
        push_good_frame(16);
        run_stream(100, 100);
        check_end("nf2", 2, 0, 3'b000);

        // Random streams on a 20-beat frame (beat index wraps in tdata), 3 frames
        sel = 3;
        for (int it = 0; it < 6; it++) begin
            tmp.delete();
            s = 0;
            for (int k = 0; k < 100; k++) begin
                x.data = (32'(FIXED) << 4) | 32'(s % 16);
                x.keep = 4'hF;
                x.last = (s == 19);
                if ($urandom_range(11) == 0) x.data = x.data ^ (32'd1 << $urandom_range(31));
                if ($urandom_range(11) == 0) x.keep = 4'($urandom_range(14));
                if ($urandom_range(14) == 0) x.last = ~x.last;
                tmp.push_back(x);
                s = (s == 19) ? 0 : s + 1;
            end
            model_start();
            n = 0;
            while (!m_done && (n < tmp.size())) begin
                model_beat(tmp[n]);
                n++;
            end
            do_start();
            src_q.delete();
            for (int k = 0; k < n; k++) src_q.push_back(tmp[k]);
            run_stream(30 + $urandom_range(70), 3000);
            check_end($sformatf("rand%0d", it), 3, m_ec, m_fl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
